// File: rtl/my_param_arb_mux.sv
// Parameterized N-to-1 arbitrating mux with a registered output stage.
// Directed-select or round-robin grant; one word per cycle throughput.
module my_param_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] input_data,
  input  logic [NUM_IN-1:0]       input_valid,
  output logic [NUM_IN-1:0]       input_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select_signal,
  output logic [WIDTH-1:0]        output_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic [SEL_W-1:0]        output_sel
);

  localparam logic [SEL_W:0]   NUM_W = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W:0]   rr_idx;
  logic             xfer;

  assign load_en = !valid_q || output_ready;

  // Pick the grant: directed select, or first valid at/after ptr (wrapping).
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    rr_idx  = '0;
    if (!mode) begin
      if ({1'b0, select_signal} < NUM_W) begin
        if (input_valid[select_signal]) begin
          gnt_vld = 1'b1;
          gnt     = select_signal;
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (rr_idx >= NUM_W) begin
          rr_idx = rr_idx - NUM_W;
        end
        if (!gnt_vld && input_valid[rr_idx[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt     = rr_idx[SEL_W-1:0];
        end
      end
    end
  end

  // Accept only the granted channel, and only when the output can load.
  always_comb begin
    input_ready = '0;
    if (!reset && load_en && gnt_vld) begin
      input_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |input_ready;

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q && !output_ready;
    if (xfer) begin
      data_d  = input_data[int'(gnt)*WIDTH +: WIDTH];
      sel_d   = gnt;
      valid_d = 1'b1;
      if (mode) begin
        ptr_d = (gnt == LAST) ? '0 : gnt + SEL_W'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign output_data  = data_q;
  assign output_valid = valid_q;
  assign output_sel   = sel_q;

endmodule

// File: tb/tb_my_param_arb_mux.sv
// Directed-vector bench for my_param_arb_mux.
// Table of cycle vectors plus hand sequences for reset and out-of-range select.
module tb_my_param_arb_mux;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_sel;

  logic [23:0]  d2_in;
  logic [2:0]   v2;
  logic [2:0]   r2;
  logic         m2;
  logic [1:0]   s2;
  logic [7:0]   o2;
  logic         ov2;
  logic         ordy2;
  logic [1:0]   os2;

  my_param_arb_mux #(.WIDTH(32), .NUM_IN(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .input_data    (in_data),
    .input_valid   (in_valid),
    .input_ready   (in_ready),
    .mode          (mode),
    .select_signal (sel),
    .output_data   (out_data),
    .output_valid  (out_valid),
    .output_ready  (out_ready),
    .output_sel    (out_sel)
  );

  my_param_arb_mux #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clock         (clock),
    .reset         (reset),
    .input_data    (d2_in),
    .input_valid   (v2),
    .input_ready   (r2),
    .mode          (m2),
    .select_signal (s2),
    .output_data   (o2),
    .output_valid  (ov2),
    .output_ready  (ordy2),
    .output_sel    (os2)
  );

  typedef struct {
    logic        md;
    logic [1:0]  sl;
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  irdy;
    logic        ov;
    logic [31:0] od;
    logic [1:0]  os;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] ch[4];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int i);
    mode      = t.md;
    sel       = t.sl;
    in_valid  = t.v;
    out_ready = t.ordy;
    #1;
    chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(t.irdy));
    @(posedge clock);
    #1;
    chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(t.ov));
    chk($sformatf("v%0d out_data", i), 64'(out_data), 64'(t.od));
    chk($sformatf("v%0d out_sel", i), 64'(out_sel), 64'(t.os));
  endtask

  function automatic vec_t mk(input logic md, input logic [1:0] sl,
                              input logic [3:0] v, input logic ordy,
                              input logic [3:0] irdy, input logic ov,
                              input logic [31:0] od, input logic [1:0] os);
    vec_t t;
    t.md = md; t.sl = sl; t.v = v; t.ordy = ordy;
    t.irdy = irdy; t.ov = ov; t.od = od; t.os = os;
    return t;
  endfunction

  initial begin
    ch[0] = 32'h1111_0000;
    ch[1] = 32'h2222_0001;
    ch[2] = 32'hDEAD_BEEF;
    ch[3] = 32'h4444_0003;
    in_data   = {ch[3], ch[2], ch[1], ch[0]};
    d2_in     = {8'h33, 8'h22, 8'h11};
    reset     = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    v2 = 3'b000; m2 = 1'b0; s2 = 2'd0; ordy2 = 1'b1;

    #2;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_sel", 64'(out_sel), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    tbl.push_back(mk(0, 2, 4'hF, 1, 4'b0100, 1, ch[2], 2));
    tbl.push_back(mk(0, 1, 4'b0101, 1, 4'b0000, 0, ch[2], 2));
    tbl.push_back(mk(0, 3, 4'b1000, 0, 4'b1000, 1, ch[3], 3));
    tbl.push_back(mk(1, 0, 4'hF, 0, 4'b0000, 1, ch[3], 3));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 0, 4'hF, 1, 4'(1 << (k % 4)), 1,
                       ch[k % 4], 2'(k % 4)));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 4'hF, 1, 4'(1 << k), 1, ch[k], 2'(k)));
    tbl.push_back(mk(1, 0, 4'b0010, 1, 4'b0010, 1, ch[1], 1));
    tbl.push_back(mk(1, 0, 4'b0001, 1, 4'b0001, 1, ch[0], 0));
    tbl.push_back(mk(1, 0, 4'hF, 1, 4'b0010, 1, ch[1], 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 4'hF, 0, 4'b0000, 1, ch[1], 1));
    tbl.push_back(mk(1, 0, 4'hF, 1, 4'b0100, 1, ch[2], 2));
    tbl.push_back(mk(1, 0, 4'h0, 1, 4'b0000, 0, ch[2], 2));
    tbl.push_back(mk(1, 0, 4'h0, 0, 4'b0000, 0, ch[2], 2));
    tbl.push_back(mk(1, 0, 4'hF, 1, 4'b1000, 1, ch[3], 3));
    tbl.push_back(mk(1, 0, 4'hF, 1, 4'b0001, 1, ch[0], 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_data", 64'(out_data), 64'd0);
    chk("midrst out_sel", 64'(out_sel), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd0);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("postrst in_ready", 64'(in_ready), 64'b0001);
    @(posedge clock);
    #1;
    chk("postrst out_valid", 64'(out_valid), 64'd1);
    chk("postrst out_sel", 64'(out_sel), 64'd0);
    chk("postrst out_data", 64'(out_data), 64'(ch[0]));
    in_valid = 4'h0;

    m2 = 1'b0; s2 = 2'd1; v2 = 3'b111; ordy2 = 1'b1;
    #1;
    chk("n3 sel1 ready", 64'(r2), 64'b010);
    @(posedge clock);
    #1;
    chk("n3 sel1 valid", 64'(ov2), 64'd1);
    chk("n3 sel1 data", 64'(o2), 64'h22);
    chk("n3 sel1 sel", 64'(os2), 64'd1);
    s2 = 2'd3; ordy2 = 1'b0;
    #1;
    chk("n3 oor stall ready", 64'(r2), 64'd0);
    @(posedge clock);
    #1;
    chk("n3 oor stall valid", 64'(ov2), 64'd1);
    chk("n3 oor stall data", 64'(o2), 64'h22);
    ordy2 = 1'b1;
    #1;
    chk("n3 oor ready", 64'(r2), 64'd0);
    @(posedge clock);
    #1;
    chk("n3 oor valid", 64'(ov2), 64'd0);
    chk("n3 oor sel", 64'(os2), 64'd1);
    chk("n3 oor data", 64'(o2), 64'h22);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/my_param_arb_mux.md
MY_PARAM_ARB_MUX -- requirements
Module: my_param_arb_mux

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: data width of each channel, in bits.
REQ-002 SHALL provide parameter NUM_IN, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL provide derived parameter SEL_W, equal to clog2(NUM_IN), default 2: width of the select and channel-id fields.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port input_data, input, NUM_IN*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port input_valid, input, NUM_IN bits: per-channel offer.
REQ-008 SHALL have port input_ready, output, NUM_IN bits: per-channel accept, combinational.
REQ-009 SHALL have port mode, input, 1 bit: 0 is directed select, 1 is round-robin arbitration.
REQ-010 SHALL have port select_signal, input, SEL_W bits: the channel to use in directed mode.
REQ-011 SHALL have port output_data, output, WIDTH bits: registered data.
REQ-012 SHALL have port output_valid, output, 1 bit: output register holds a word.
REQ-013 SHALL have port output_ready, input, 1 bit: consumer accepts the word.
REQ-014 SHALL have port output_sel, output, SEL_W bits: id of the channel that supplied output_data.

Function
REQ-015 The block SHALL define load_en as !output_valid || output_ready.
REQ-016 A transfer on channel i SHALL occur when input_valid[i] && input_ready[i]; at most one channel SHALL be granted per cycle.
REQ-017 In directed mode (mode=0), grant SHALL be select_signal when select_signal < NUM_IN and input_valid[select_signal]=1; otherwise there is no grant.
REQ-018 In round-robin mode (mode=1), grant SHALL be the first valid channel found searching upward from ptr, wrapping from NUM_IN-1 to 0; with no valid channel there is no grant.
REQ-019 input_ready[i] SHALL be load_en && (a grant exists) && (grant == i); every other input_ready bit SHALL be 0.
REQ-020 On a transfer, the block SHALL load output_data from the granted channel's data, load output_sel with the grant, and set output_valid=1 at the next edge (latency 1 cycle).
REQ-021 When output_valid && output_ready and there is no transfer, output_valid SHALL clear; output_data and output_sel SHALL hold their old values.
REQ-022 When output_valid && !output_ready, output_data, output_sel and output_valid SHALL hold, and all input_ready bits SHALL be 0 (stall).
REQ-023 When output_valid, output_ready and a grant all occur together, the block SHALL unload and load in the same cycle, giving a sustained throughput of 1 word per cycle.
REQ-024 ptr SHALL update only on a transfer in round-robin mode, to (grant+1) mod NUM_IN, wrapping NUM_IN-1 to 0; directed-mode transfers SHALL leave ptr unchanged.
REQ-025 A change of mode or select_signal SHALL take effect on the grant of the same cycle; a word already held in the output register SHALL be unaffected.
REQ-026 An input_valid bit on a non-granted channel SHALL produce no side effect; that channel waits.

Reset
REQ-027 While reset=1, asynchronously, output_valid SHALL be 0, output_data SHALL be 0, output_sel SHALL be 0, ptr SHALL be 0, and all input_ready bits SHALL be 0.
REQ-028 Assertion of reset mid-operation SHALL discard any held word; the first edge after release SHALL be able to perform a transfer.

Verification
REQ-029 Directed mode: NUM_IN=4, mode=0, select_signal=2, input_valid=4'b1111, channel 2 data=32'hDEAD_BEEF, output_ready=1 -> input_ready=4'b0100; one cycle later output_data=DEADBEEF, output_sel=2, output_valid=1.
REQ-030 Round-robin fairness: mode=1, all four channels valid, output_ready=1 for 8 cycles -> output_sel sequence is 0,1,2,3,0,1,2,3 and one word is delivered per cycle.
REQ-031 Round-robin skip and wrap: ptr=3, input_valid=4'b0010 -> grant is 1 and ptr becomes 2; then input_valid=4'b0001 -> grant is 0 and ptr becomes 1.
REQ-032 Backpressure: output_valid=1, output_ready=0 for 3 cycles with all channels valid -> input_ready=0 and output held for those 3 cycles; on the output_ready=1 cycle, unload and load happen together.
REQ-033 Out-of-range select: NUM_IN=3, SEL_W=2, select_signal=3, mode=0 -> no grant, input_ready=0, and output_valid clears after the consumer accepts the held word.
REQ-034 Reset mid-stream: reset pulsed asynchronously between edges while output_valid=1 -> output_valid, output_data, output_sel and ptr are all 0 immediately; after release with all channels valid in mode=1, the first grant is channel 0.
